multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Control FSM for the multi-cycle RISC-V RV32I datapath; drives the ALU control interface (alu_ctrl, operand selects) and consumes the ALU zero flag.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Emits register/PC/IR/memory strobes and waits on a memory-ready handshake.
- Replaces the single-cycle main decoder when the shared-memory multi-cycle datapath is built.

Parameters:
- RESET_STATE, 4'd0, state encoding entered on reset (FETCH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- pc_write  out  1  PC load strobe
- ir_write  out  1  IR and old_pc load strobe
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write
- adr_src  out  1  memory address: 0 = PC, 1 = result
- result_src  out  2  00 = ALUOut reg, 01 = mem data, 10 = ALU result
- alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- alu_ctrl  out  4  ALU operation code
- illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Clock and reset: clk is the only clock. rst_n is asynchronous, active-low.
- Reset: state=FETCH, illegal=0. While rst_n is low, all strobes (pc_write, ir_write, mem_read, mem_write, reg_write) are forced 0 and all selects are 0.
- Output decode: outputs are combinational from state. The exceptions are alu_ctrl in EXECR/EXECI, which also uses funct3/funct7b5, and pc_write in BRANCH, which also uses zero.
- alu_ctrl codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 1000 auipc, 1001 lui, 1010 sll, 1011 sra, 1100 srl.
- imm_src is decoded from opcode in every state.
- FETCH: adr_src=0, mem_read=1, A=PC, B=4, add, result_src=10.
  - If mem_ready: ir_write=1, pc_write=1, go to DECODE.
  - Else: hold, with no IR/PC write.
- DECODE: A=old_pc, B=imm, add (precomputes branch/JAL target into ALUOut). Dispatch on opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 or 0010111 -> UPPER
  - any other opcode -> TRAP
- MEMADR: A=rs1, B=imm, add. Go to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: adr_src=1, result_src=00, mem_read=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, go to FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. Wait for mem_ready, then go to FETCH.
  - mem_write stays high every waiting cycle.
- EXECR: A=rs1, B=rs2, go to ALUWB. alu_ctrl by funct3:
  - 000: sub if funct7b5, else add
  - 001: sll
  - 010: slt
  - 011: sltu
  - 100: xor
  - 101: sra if funct7b5, else srl
  - 110: or
  - 111: and
- EXECI: A=rs1, B=imm, go to ALUWB. Same funct3 table as EXECR, except funct3=000 is always add; funct7b5 affects only 101.
- ALUWB: result_src=00, reg_write=1, go to FETCH.
- BRANCH: A=rs1, B=rs2, result_src=00, go to FETCH. Per funct3:
  - 000 (beq): alu_ctrl=sub, pc_write=zero
  - 001 (bne): alu_ctrl=sub, pc_write=~zero
  - 100 (blt): alu_ctrl=slt, pc_write=~zero
  - 101 (bge): alu_ctrl=slt, pc_write=zero
  - 110 (bltu): alu_ctrl=sltu, pc_write=~zero
  - 111 (bgeu): alu_ctrl=sltu, pc_write=zero
  - 010 or 011: no pc_write, go to TRAP instead of FETCH.
- JAL: result_src=00, pc_write=1, A=old_pc, B=4, add, go to ALUWB.
- JALR: A=rs1, B=imm, add, result_src=10, pc_write=1, go to LINK.
- LINK: A=old_pc, B=4, add, result_src=10, reg_write=1, go to FETCH.
- UPPER: B=imm, go to ALUWB.
  - opcode 0110111 (LUI): alu_ctrl=1001.
  - opcode 0010111 (AUIPC): A=old_pc, alu_ctrl=1000.
- TRAP: illegal=1, all strobes 0. Held until reset.
- Latencies with zero-wait memory:
  - R/I/LUI/AUIPC: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - JAL: 4 cycles
  - JALR: 4 cycles
- Each mem_ready wait adds 1 cycle per stalled cycle.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- Reset asserted mid-instruction aborts immediately. No partial write occurs after rst_n falls.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1: states FETCH, DECODE, EXECR, ALUWB. alu_ctrl=0000 in EXECR; reg_write=1 only in cycle 4.
- sub 0x402081B3 -> alu_ctrl=0001. srai 0x4020D093 -> alu_ctrl=1011. addi with instr[30]=1 (0x40008093) -> alu_ctrl=0000.
- lw 0x0000A183 with mem_ready low for 3 cycles in MEMREAD: mem_read held 4 cycles, adr_src=1; MEMWB follows with result_src=01 and reg_write=1.
- Branches:
  - beq with zero=1: pc_write=1 in BRANCH.
  - bge (funct3=101) with zero=0: pc_write=0.
  - bltu: alu_ctrl=0110.
- jalr 0x000080E7: JALR has pc_write=1 and result_src=10; LINK has reg_write=1 with A=old_pc, B=4.
- Opcode 0x7F: DECODE -> TRAP; illegal=1 held through 10 cycles. Asserting rst_n low clears illegal at once, and FETCH resumes after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I datapath.
// Sequences fetch / decode / execute / memory / writeback, drives the ALU
// control and operand selects, and waits on the memory-ready handshake.
//
// Handshake: a memory access requested in FETCH, MEMREAD or MEMWRITE
// completes in the cycle mem_ready is high. Until then the request strobe
// stays high and the FSM holds. mem_ready is ignored in every other state.
`timescale 1ns/1ps
module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [3:0] alu_ctrl,
    output logic       illegal,
    output logic [3:0] dbg_state_o
);

    // State encodings
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_LINK     = 4'd12;
    localparam logic [3:0] S_UPPER    = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd14;

    // Opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_AUIPC = 4'b1000;
    localparam logic [3:0] ALU_LUI   = 4'b1001;
    localparam logic [3:0] ALU_SLL   = 4'b1010;
    localparam logic [3:0] ALU_SRA   = 4'b1011;
    localparam logic [3:0] ALU_SRL   = 4'b1100;

    // Operand select encodings
    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_OLDPC = 2'b01;
    localparam logic [1:0] A_RS1   = 2'b10;
    localparam logic [1:0] B_RS2   = 2'b00;
    localparam logic [1:0] B_IMM   = 2'b01;
    localparam logic [1:0] B_FOUR  = 2'b10;
    localparam logic [1:0] R_ALUOUT = 2'b00;
    localparam logic [1:0] R_MEM    = 2'b01;
    localparam logic [1:0] R_ALU    = 2'b10;

    logic [3:0] state_q, state_d;
    logic       illegal_q, illegal_d;

    logic       pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c, adr_src_c;
    logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c;
    logic [2:0] imm_src_c;
    logic [3:0] alu_ctrl_c;

    // funct3 arithmetic decode; allow_sub separates R-type (sub) from I-type (addi)
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic f7b5,
                                            input logic allow_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (allow_sub && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // State register and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UPPER;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = (funct3[2:1] == 2'b01) ? S_TRAP : S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_LINK;
            S_LINK:     state_d = S_FETCH;
            S_UPPER:    state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
        if (state_d == S_TRAP) begin
            illegal_d = 1'b1;
        end
    end

    // Immediate format from opcode, independent of state
    always_comb begin
        case (opcode)
            OP_STORE:         imm_src_c = 3'b001;
            OP_BRANCH:        imm_src_c = 3'b010;
            OP_JAL:           imm_src_c = 3'b011;
            OP_LUI, OP_AUIPC: imm_src_c = 3'b100;
            default:          imm_src_c = 3'b000;
        endcase
    end

    // Output decode from state (plus funct fields in EXEC*, zero in BRANCH)
    always_comb begin
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        result_src_c = R_ALUOUT;
        alu_src_a_c  = A_PC;
        alu_src_b_c  = B_RS2;
        alu_ctrl_c   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read_c   = 1'b1;
                alu_src_b_c  = B_FOUR;
                result_src_c = R_ALU;
                ir_write_c   = mem_ready;
                pc_write_c   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a_c = A_OLDPC;
                alu_src_b_c = B_IMM;
            end
            S_MEMADR: begin
                alu_src_a_c = A_RS1;
                alu_src_b_c = B_IMM;
            end
            S_MEMREAD: begin
                adr_src_c  = 1'b1;
                mem_read_c = 1'b1;
            end
            S_MEMWB: begin
                result_src_c = R_MEM;
                reg_write_c  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_c = A_RS1;
                alu_ctrl_c  = arith_op(funct3, funct7b5, 1'b1);
            end
            S_EXECI: begin
                alu_src_a_c = A_RS1;
                alu_src_b_c = B_IMM;
                alu_ctrl_c  = arith_op(funct3, funct7b5, 1'b0);
            end
            S_ALUWB: reg_write_c = 1'b1;
            S_BRANCH: begin
                alu_src_a_c = A_RS1;
                case (funct3)
                    3'b000: begin alu_ctrl_c = ALU_SUB;  pc_write_c = zero;  end
                    3'b001: begin alu_ctrl_c = ALU_SUB;  pc_write_c = ~zero; end
                    3'b100: begin alu_ctrl_c = ALU_SLT;  pc_write_c = ~zero; end
                    3'b101: begin alu_ctrl_c = ALU_SLT;  pc_write_c = zero;  end
                    3'b110: begin alu_ctrl_c = ALU_SLTU; pc_write_c = ~zero; end
                    3'b111: begin alu_ctrl_c = ALU_SLTU; pc_write_c = zero;  end
                    default: ;
                endcase
            end
            S_JAL: begin
                pc_write_c  = 1'b1;
                alu_src_a_c = A_OLDPC;
                alu_src_b_c = B_FOUR;
            end
            S_JALR: begin
                alu_src_a_c  = A_RS1;
                alu_src_b_c  = B_IMM;
                result_src_c = R_ALU;
                pc_write_c   = 1'b1;
            end
            S_LINK: begin
                alu_src_a_c  = A_OLDPC;
                alu_src_b_c  = B_FOUR;
                result_src_c = R_ALU;
                reg_write_c  = 1'b1;
            end
            S_UPPER: begin
                alu_src_b_c = B_IMM;
                if (opcode == OP_LUI) begin
                    alu_ctrl_c = ALU_LUI;
                end else begin
                    alu_src_a_c = A_OLDPC;
                    alu_ctrl_c  = ALU_AUIPC;
                end
            end
            default: ;
        endcase
    end

    // While reset is held every strobe and select is forced low
    always_comb begin
        pc_write    = rst_n & pc_write_c;
        ir_write    = rst_n & ir_write_c;
        mem_read    = rst_n & mem_read_c;
        mem_write   = rst_n & mem_write_c;
        reg_write   = rst_n & reg_write_c;
        adr_src     = rst_n & adr_src_c;
        result_src  = rst_n ? result_src_c : 2'b00;
        alu_src_a   = rst_n ? alu_src_a_c  : 2'b00;
        alu_src_b   = rst_n ? alu_src_b_c  : 2'b00;
        imm_src     = rst_n ? imm_src_c    : 3'b000;
        alu_ctrl    = rst_n ? alu_ctrl_c   : 4'b0000;
        illegal     = illegal_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed test-plan cases with literal
// expectations, then randomized instruction streams with random memory
// stalls, zero flags and aborting resets, all checked cycle by cycle
// against a phase-sequence model of the instruction flow.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  localparam int W   = 20;
  localparam int NPH = 15;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic pc_write, ir_write, mem_read, mem_write, reg_write, adr_src, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl, dbg_state_o;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .adr_src(adr_src),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_ctrl(alu_ctrl), .illegal(illegal), .dbg_state_o(dbg_state_o)
  );

  // ---------------- model ----------------
  // Phases an instruction walks through; the plan for an instruction is a
  // list of these, memory phases repeat while mem_ready is low.
  typedef enum int {
    P_FETCH, P_DECODE, P_ADDR, P_LOAD, P_LOADWB, P_STORE, P_ALU_R, P_ALU_I,
    P_WB, P_BR, P_JAL, P_JALR, P_LINK, P_UPPER, P_TRAP
  } phase_e;

  phase_e plan[$];
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] cur_ins = '0;
  phase_e cur_phase = P_FETCH;

  // observations of the last run_instr, per phase
  logic [3:0] obs_alu[NPH];
  logic       obs_pcw[NPH];
  logic       obs_rw[NPH];
  logic [1:0] obs_rs[NPH];
  logic [1:0] obs_a[NPH];
  logic [1:0] obs_b[NPH];
  int n_mr, n_mr_adr, rw_cnt, rw_at, ill_cnt, ncyc;

  function automatic logic [W-1:0] dut_vec();
    return {pc_write, ir_write, mem_read, mem_write, reg_write, adr_src,
            result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl, illegal};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    if (op == 7'b0100011) return 3'b001;
    if (op == 7'b1100011) return 3'b010;
    if (op == 7'b1101111) return 3'b011;
    if (op == 7'b0110111 || op == 7'b0010111) return 3'b100;
    return 3'b000;
  endfunction

  // add, sll, slt, sltu, xor, srl, or, and by funct3; sub/sra by instr[30]
  function automatic logic [3:0] arith(input logic [2:0] f3, input logic f7, input bit is_r);
    logic [3:0] base[8];
    base = '{4'd0, 4'd10, 4'd5, 4'd6, 4'd4, 4'd12, 4'd3, 4'd2};
    if (f3 == 3'd0 && is_r && f7) return 4'd1;
    if (f3 == 3'd5 && f7) return 4'd11;
    return base[f3];
  endfunction

  function automatic logic [W-1:0] model(input phase_e p, input logic [31:0] ins,
                                         input logic z, input logic rdy);
    logic pcw, irw, mr, mw, rw, adr, ill;
    logic [1:0] rs, a, b;
    logic [3:0] alu;
    logic [2:0] f3;
    pcw = 0; irw = 0; mr = 0; mw = 0; rw = 0; adr = 0; ill = 0;
    rs = 0; a = 0; b = 0; alu = 0;
    f3 = ins[14:12];
    case (p)
      P_FETCH:  begin mr = 1; b = 2; rs = 2; irw = rdy; pcw = rdy; end
      P_DECODE: begin a = 1; b = 1; end
      P_ADDR:   begin a = 2; b = 1; end
      P_LOAD:   begin adr = 1; mr = 1; end
      P_LOADWB: begin rs = 1; rw = 1; end
      P_STORE:  begin adr = 1; mw = 1; end
      P_ALU_R:  begin a = 2; b = 0; alu = arith(f3, ins[30], 1'b1); end
      P_ALU_I:  begin a = 2; b = 1; alu = arith(f3, ins[30], 1'b0); end
      P_WB:     rw = 1;
      P_BR: begin
        a = 2;
        if (f3 != 3'd2 && f3 != 3'd3) begin
          if (f3 < 3'd4) alu = 4'd1;
          else if (f3 < 3'd6) alu = 4'd5;
          else alu = 4'd6;
          // beq, bge, bgeu take the branch when the comparison yields zero
          pcw = (f3 == 3'd0 || f3 == 3'd5 || f3 == 3'd7) ? z : !z;
        end
      end
      P_JAL:    begin pcw = 1; a = 1; b = 2; end
      P_JALR:   begin a = 2; b = 1; rs = 2; pcw = 1; end
      P_LINK:   begin a = 1; b = 2; rs = 2; rw = 1; end
      P_UPPER: begin
        b = 1;
        if (ins[6:0] == 7'b0110111) alu = 4'd9;
        else begin a = 1; alu = 4'd8; end
      end
      default:  ill = 1;
    endcase
    return {pcw, irw, mr, mw, rw, adr, rs, a, b, imm_of(ins[6:0]), alu, ill};
  endfunction

  task automatic build_plan(input logic [31:0] ins);
    plan.delete();
    plan.push_back(P_FETCH);
    plan.push_back(P_DECODE);
    case (ins[6:0])
      7'b0000011: begin plan.push_back(P_ADDR); plan.push_back(P_LOAD); plan.push_back(P_LOADWB); end
      7'b0100011: begin plan.push_back(P_ADDR); plan.push_back(P_STORE); end
      7'b0110011: begin plan.push_back(P_ALU_R); plan.push_back(P_WB); end
      7'b0010011: begin plan.push_back(P_ALU_I); plan.push_back(P_WB); end
      7'b1100011: begin
        plan.push_back(P_BR);
        if (ins[14:13] == 2'b01) plan.push_back(P_TRAP);
      end
      7'b1101111: begin plan.push_back(P_JAL); plan.push_back(P_WB); end
      7'b1100111: begin plan.push_back(P_JALR); plan.push_back(P_LINK); end
      7'b0110111, 7'b0010111: begin plan.push_back(P_UPPER); plan.push_back(P_WB); end
      default: plan.push_back(P_TRAP);
    endcase
  endtask

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // compare process: one expected output vector per driven cycle
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = dut_vec();
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL outputs instr=%08h phase=%s: got %b, expected %b",
                   cur_ins, cur_phase.name(), g, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered just after a posedge with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] ins, input bit rnd, input int mem_stalls,
                           input logic zval, input int trap_cycles, input int abort_after,
                           output bit need_reset);
    phase_e p;
    int stalls;
    int tcnt;
    stalls = 0;
    tcnt = 0;
    need_reset = 1'b0;
    build_plan(ins);
    cur_ins = ins;
    opcode = ins[6:0];
    funct3 = ins[14:12];
    funct7b5 = ins[30];
    for (int i = 0; i < NPH; i++) begin
      obs_alu[i] = '0; obs_pcw[i] = 0; obs_rw[i] = 0; obs_rs[i] = '0; obs_a[i] = '0; obs_b[i] = '0;
    end
    n_mr = 0; n_mr_adr = 0; rw_cnt = 0; rw_at = 0; ill_cnt = 0; ncyc = 0;
    while (plan.size() > 0) begin
      p = plan[0];
      cur_phase = p;
      if (rnd) begin
        zero = 1'($urandom_range(0, 1));
        mem_ready = (stalls >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
      end else begin
        zero = zval;
        mem_ready = ((p == P_LOAD || p == P_STORE) && stalls < mem_stalls) ? 1'b0 : 1'b1;
      end
      exp_q.push_back(model(p, ins, zero, mem_ready));
      #2;
      obs_alu[int'(p)] = alu_ctrl;
      obs_pcw[int'(p)] = pc_write;
      obs_rw[int'(p)]  = reg_write;
      obs_rs[int'(p)]  = result_src;
      obs_a[int'(p)]   = alu_src_a;
      obs_b[int'(p)]   = alu_src_b;
      if (mem_read) n_mr++;
      if (mem_read && adr_src) n_mr_adr++;
      if (reg_write) begin rw_cnt++; rw_at = ncyc + 1; end
      if (illegal) ill_cnt++;
      ncyc++;
      @(posedge clk); #1;
      if (p == P_TRAP) begin
        tcnt++;
        if (tcnt >= trap_cycles) begin need_reset = 1'b1; return; end
      end else if ((p == P_FETCH || p == P_LOAD || p == P_STORE) && !mem_ready) begin
        stalls++;
      end else begin
        void'(plan.pop_front());
        stalls = 0;
      end
      if (abort_after > 0 && ncyc >= abort_after && plan.size() > 0) begin
        need_reset = 1'b1;
        return;
      end
    end
  endtask

  // Asserts reset between edges, checks everything drops at once, releases.
  task automatic do_reset(input string name);
    @(negedge clk); #2;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    check({name, "_outputs_zero"}, 32'(dut_vec()), 32'd0);
    check({name, "_state_fetch"}, 32'(dbg_state_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- main ----------------
  logic [6:0] ops[10];
  initial begin
    bit nr;
    logic [31:0] ins;
    int k;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};

    // power-on reset
    #3;
    check("por_outputs_zero", 32'(dut_vec()), 32'd0);
    check("por_state_fetch", 32'(dbg_state_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // add x3,x1,x2
    run_instr(32'h002081B3, 0, 0, 1'b0, 1, 0, nr);
    check("add_latency", ncyc, 4);
    check("add_alu", 32'(obs_alu[int'(P_ALU_R)]), 32'h0);
    check("add_rw_cycle", rw_at, 4);
    check("add_rw_count", rw_cnt, 1);
    // sub, srai, addi with instr[30]=1
    run_instr(32'h402081B3, 0, 0, 1'b0, 1, 0, nr);
    check("sub_alu", 32'(obs_alu[int'(P_ALU_R)]), 32'h1);
    run_instr(32'h4020D093, 0, 0, 1'b0, 1, 0, nr);
    check("srai_alu", 32'(obs_alu[int'(P_ALU_I)]), 32'hB);
    run_instr(32'h40008093, 0, 0, 1'b0, 1, 0, nr);
    check("addi_b30_alu", 32'(obs_alu[int'(P_ALU_I)]), 32'h0);
    // lw with three wait cycles in MEMREAD
    run_instr(32'h0000A183, 0, 3, 1'b0, 1, 0, nr);
    check("lw_latency", ncyc, 8);
    check("lw_memread_adr1_cycles", n_mr_adr, 4);
    check("lw_memread_total", n_mr, 5);
    check("lw_wb_result_src", 32'(obs_rs[int'(P_LOADWB)]), 32'h1);
    check("lw_wb_reg_write", 32'(obs_rw[int'(P_LOADWB)]), 32'h1);
    // sw zero-wait
    run_instr(32'h0020A023, 0, 0, 1'b0, 1, 0, nr);
    check("sw_latency", ncyc, 4);
    // branches
    run_instr(32'h00208063, 0, 0, 1'b1, 1, 0, nr);
    check("beq_z1_pc_write", 32'(obs_pcw[int'(P_BR)]), 32'h1);
    check("beq_latency", ncyc, 3);
    run_instr(32'h0020D063, 0, 0, 1'b0, 1, 0, nr);
    check("bge_z0_pc_write", 32'(obs_pcw[int'(P_BR)]), 32'h0);
    run_instr(32'h0020E063, 0, 0, 1'b0, 1, 0, nr);
    check("bltu_alu", 32'(obs_alu[int'(P_BR)]), 32'h6);
    // jal, jalr
    run_instr(32'h008000EF, 0, 0, 1'b0, 1, 0, nr);
    check("jal_latency", ncyc, 4);
    run_instr(32'h000080E7, 0, 0, 1'b0, 1, 0, nr);
    check("jalr_latency", ncyc, 4);
    check("jalr_pc_write", 32'(obs_pcw[int'(P_JALR)]), 32'h1);
    check("jalr_result_src", 32'(obs_rs[int'(P_JALR)]), 32'h2);
    check("link_reg_write", 32'(obs_rw[int'(P_LINK)]), 32'h1);
    check("link_src_a", 32'(obs_a[int'(P_LINK)]), 32'h1);
    check("link_src_b", 32'(obs_b[int'(P_LINK)]), 32'h2);
    // lui / auipc
    run_instr(32'h123450B7, 0, 0, 1'b0, 1, 0, nr);
    check("lui_latency", ncyc, 4);
    check("lui_alu", 32'(obs_alu[int'(P_UPPER)]), 32'h9);
    run_instr(32'h12345097, 0, 0, 1'b0, 1, 0, nr);
    check("auipc_alu", 32'(obs_alu[int'(P_UPPER)]), 32'h8);
    check("auipc_src_a", 32'(obs_a[int'(P_UPPER)]), 32'h1);
    // illegal opcode: sticky for 10 cycles, cleared by reset
    run_instr(32'h0000007F, 0, 0, 1'b0, 10, 0, nr);
    check("trap_needs_reset", 32'(nr), 32'h1);
    check("trap_illegal_cycles", ill_cnt, 10);
    do_reset("trap_reset");
    run_instr(32'h00108093, 0, 0, 1'b0, 1, 0, nr);
    check("after_reset_addi_latency", ncyc, 4);
    // branch with funct3=010 traps
    run_instr(32'h0020A063, 0, 0, 1'b1, 2, 0, nr);
    check("br010_pc_write", 32'(obs_pcw[int'(P_BR)]), 32'h0);
    check("br010_latency", ncyc, 5);
    do_reset("br010_reset");
    // store stalled in MEMWRITE, aborted by reset
    run_instr(32'h0020A023, 0, 5, 1'b0, 1, 4, nr);
    check("sw_abort_requested", 32'(nr), 32'h1);
    do_reset("sw_abort_reset");

    // randomized stream
    for (int n = 0; n < 300; n++) begin
      int ab;
      ins = $urandom();
      k = $urandom_range(0, 10);
      if (k < 10) ins[6:0] = ops[k];
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 4) : 0;
      run_instr(ins, 1, 0, 1'b0, $urandom_range(1, 4), ab, nr);
      if (nr) do_reset("rand_reset");
    end

    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
